// File: rtl/wb_dtlb_pkg.sv
// Shared types and constants for the data-side TLB: page geometry,
// FSM state encoding and the registered wishbone request.
package mmu_pkg;
    localparam int PAGE_BITS_DEF = 12;
    localparam int VPN_W         = 32 - PAGE_BITS_DEF;
    localparam int PPN_W         = VPN_W;
    localparam int WB_ADR_W      = 30;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_ISSUE,
        ST_FAULT
    } state_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic [2:0]  cti;
        logic [1:0]  bte;
    } wb_req_t;
endpackage

// File: rtl/wb_dtlb_if.sv
// Classic wishbone bus bundle; AW is 32 on the lm32 side (byte address)
// and 30 on the arbiter side (word address).
interface wb_dtlb_if #(parameter int AW = 32) ();
    logic [AW-1:0] adr;
    logic [31:0]   dat_w;
    logic [31:0]   dat_r;
    logic [3:0]    sel;
    logic          cyc;
    logic          stb;
    logic          we;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic          ack;
    logic          err;

    modport master (output adr, dat_w, sel, cyc, stb, we, cti, bte,
                    input  dat_r, ack, err);
    modport slave  (input  adr, dat_w, sel, cyc, stb, we, cti, bte,
                    output dat_r, ack, err);
endinterface

// File: rtl/wb_dtlb_cam.sv
// Fully-associative translation store: entry arrays, round-robin refill
// pointer, flush, and lowest-index-wins lookup.
module wb_dtlb_cam #(
    parameter int ENTRIES = 8,
    parameter int VW      = 20
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic [VW-1:0] lk_vpn,
    input  logic          wr,
    input  logic [VW-1:0] wr_vpn,
    input  logic [VW-1:0] wr_ppn,
    input  logic          wr_v,
    input  logic          flush,
    output logic          hit,
    output logic [VW-1:0] ppn
);
    localparam int PW = $clog2(ENTRIES);

    logic [ENTRIES-1:0]         vld;
    logic [ENTRIES-1:0][VW-1:0] vpn_q;
    logic [ENTRIES-1:0][VW-1:0] ppn_q;
    logic [PW-1:0]              ptr;
    logic [ENTRIES-1:0]         lk_m;
    logic [ENTRIES-1:0]         wr_m;
    logic [PW-1:0]              wr_idx;
    logic [PW-1:0]              ptr_base;
    logic [PW-1:0]              slot;

    // Write match ignores the valid bit so a stale VPN is reused in place.
    for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
        assign lk_m[g] = vld[g] && (vpn_q[g] == lk_vpn);
        assign wr_m[g] = (vpn_q[g] == wr_vpn);
    end

    always_comb begin
        hit    = |lk_m;
        ppn    = '0;
        wr_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (lk_m[i]) ppn    = ppn_q[i];
            if (wr_m[i]) wr_idx = PW'(i);
        end
        ptr_base = flush ? '0 : ptr;
        slot     = (|wr_m) ? wr_idx : ptr_base;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld   <= '0;
            vpn_q <= '0;
            ppn_q <= '0;
            ptr   <= '0;
        end else begin
            if (flush) begin
                vld <= '0;
                ptr <= '0;
            end
            // Later assignment wins, so a same-cycle write lands after the flush.
            if (wr) begin
                vpn_q[slot] <= wr_vpn;
                ppn_q[slot] <= wr_ppn;
                vld[slot]   <= wr_v;
                if (!(|wr_m)) ptr <= ptr_base + 1'b1;
            end
        end
    end
endmodule

// File: rtl/wb_dtlb.sv
// lm32 data-bus TLB: registers a master request, translates it in one
// lookup cycle, then either forwards it to the arbiter or faults it.
module wb_dtlb
    import mmu_pkg::*;
#(
    parameter int ENTRIES   = 8,
    parameter int PAGE_BITS = PAGE_BITS_DEF
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    wb_dtlb_if.slave              m,
    wb_dtlb_if.master             s,
    input  logic                  tlb_en,
    input  logic                  tlb_wr,
    input  logic [31-PAGE_BITS:0] tlb_wr_vpn,
    input  logic [31-PAGE_BITS:0] tlb_wr_ppn,
    input  logic                  tlb_wr_v,
    input  logic                  tlb_flush,
    output logic [31:0]           fault_vaddr,
    output logic                  miss_o
);
    localparam int VW = 32 - PAGE_BITS;

    state_t                state;
    wb_req_t               req;
    logic [WB_ADR_W-1:0]   s_adr;
    logic [WB_ADR_W-1:0]   phys_adr;
    logic                  s_cyc;
    logic                  err_q;
    logic                  cam_hit;
    logic [VW-1:0]         cam_ppn;
    logic                  go;
    logic                  issue;

    wb_dtlb_cam #(.ENTRIES(ENTRIES), .VW(VW)) u_cam (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .lk_vpn    (req.adr[31:PAGE_BITS]),
        .wr        (tlb_wr),
        .wr_vpn    (tlb_wr_vpn),
        .wr_ppn    (tlb_wr_ppn),
        .wr_v      (tlb_wr_v),
        .flush     (tlb_flush),
        .hit       (cam_hit),
        .ppn       (cam_ppn)
    );

    assign phys_adr = tlb_en ? {cam_ppn, req.adr[PAGE_BITS-1:2]} : req.adr[31:2];
    assign go       = !tlb_en || cam_hit;
    assign issue    = (state == ST_ISSUE) && m.cyc;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            req         <= '0;
            s_adr       <= '0;
            s_cyc       <= 1'b0;
            err_q       <= 1'b0;
            miss_o      <= 1'b0;
            fault_vaddr <= '0;
        end else begin
            err_q  <= 1'b0;
            miss_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (m.cyc && m.stb && !m.ack && !m.err) begin
                        req   <= '{adr: m.adr, dat: m.dat_w, sel: m.sel, we: m.we,
                                   cti: m.cti, bte: m.bte};
                        state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (!m.cyc) begin
                        state <= ST_IDLE;
                    end else if (go) begin
                        s_adr <= phys_adr;
                        s_cyc <= 1'b1;
                        state <= ST_ISSUE;
                    end else begin
                        err_q       <= 1'b1;
                        miss_o      <= 1'b1;
                        fault_vaddr <= req.adr;
                        state       <= ST_FAULT;
                    end
                end
                ST_ISSUE: begin
                    // s_adr was captured in LOOKUP, so TLB updates here cannot disturb it.
                    if (!m.cyc || s.ack || s.err) begin
                        s_cyc <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign s.adr   = s_adr;
    assign s.dat_w = req.dat;
    assign s.sel   = req.sel;
    assign s.we    = req.we;
    assign s.cti   = req.cti;
    assign s.bte   = req.bte;
    assign s.cyc   = s_cyc;
    assign s.stb   = s_cyc;
    assign m.dat_r = s.dat_r;
    assign m.ack   = issue && s.ack;
    assign m.err   = err_q || (issue && s.err);
endmodule

// File: tb/tb_wb_dtlb.sv
// Randomised scoreboard bench for wb_dtlb against a page-table level model.
module tb_wb_dtlb;
    import mmu_pkg::*;
    localparam int ENTRIES = 8;
    localparam int PB      = 12;
    localparam int VW      = 32 - PB;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic          tlb_en, tlb_wr, tlb_wr_v, tlb_flush, miss_o;
    logic [VW-1:0] tlb_wr_vpn, tlb_wr_ppn;
    logic [31:0]   fault_vaddr;

    wb_dtlb_if #(.AW(32)) m_bus ();
    wb_dtlb_if #(.AW(30)) s_bus ();

    wb_dtlb #(.ENTRIES(ENTRIES), .PAGE_BITS(PB)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .m(m_bus), .s(s_bus),
        .tlb_en(tlb_en), .tlb_wr(tlb_wr), .tlb_wr_vpn(tlb_wr_vpn),
        .tlb_wr_ppn(tlb_wr_ppn), .tlb_wr_v(tlb_wr_v), .tlb_flush(tlb_flush),
        .fault_vaddr(fault_vaddr), .miss_o(miss_o)
    );

    int n_vec = 0, n_miss = 0;
    int term_cnt = 0, scyc_cnt = 0, miss_cnt = 0, n_fault = 0;
    int lat_lo = 0, lat_hi = 3;
    bit allow_serr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    typedef struct { logic err; logic fault; logic rd; logic [31:0] dat; logic [31:0] va; } resp_t;
    typedef struct { logic [29:0] adr; logic we; logic [31:0] dat; logic [3:0] sel; logic err; } sreq_t;
    resp_t rq[$];
    sreq_t sq[$];

    // Reference TLB: a table of (vpn, ppn, valid) plus a refill pointer.
    logic [VW-1:0] r_vpn[ENTRIES];
    logic [VW-1:0] r_ppn[ENTRIES];
    bit            r_v[ENTRIES];
    int            r_ptr;
    logic [31:0]   rmem[logic [29:0]];
    logic [31:0]   smem[logic [29:0]];

    function automatic logic [31:0] init_word(input logic [29:0] a);
        return {a, 2'b01} ^ 32'hA5C3_0F1E;
    endfunction
    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] sel);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction
    function automatic logic [31:0] rget(input logic [29:0] a);
        return rmem.exists(a) ? rmem[a] : init_word(a);
    endfunction
    function automatic logic [31:0] sget(input logic [29:0] a);
        return smem.exists(a) ? smem[a] : init_word(a);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin r_vpn[i] = '0; r_ppn[i] = '0; r_v[i] = 0; end
        r_ptr = 0;
    endfunction
    function automatic void model_flush();
        for (int i = 0; i < ENTRIES; i++) r_v[i] = 0;
        r_ptr = 0;
    endfunction
    function automatic void model_write(input logic [VW-1:0] vpn, input logic [VW-1:0] ppn, input bit v);
        int slot = -1;
        for (int i = 0; i < ENTRIES; i++) if (slot < 0 && r_vpn[i] == vpn) slot = i;
        if (slot < 0) begin slot = r_ptr; r_ptr = (r_ptr + 1) % ENTRIES; end
        r_vpn[slot] = vpn; r_ppn[slot] = ppn; r_v[slot] = v;
    endfunction
    function automatic bit model_xlate(input logic [31:0] va, input bit en, output logic [29:0] pa);
        pa = va[31:2];
        if (!en) return 1;
        for (int i = 0; i < ENTRIES; i++)
            if (r_v[i] && r_vpn[i] == va[31:PB]) begin pa = {r_ppn[i], va[PB-1:2]}; return 1; end
        return 0;
    endfunction

    // Slave: random latency, checks the request against the scoreboard.
    bit    sbusy = 0;
    int    slat = 0;
    sreq_t cur;
    always @(posedge sys_clk) begin
        #1;
        if (!sys_rst_n) begin
            sbusy = 0; s_bus.ack = 0; s_bus.err = 0; s_bus.dat_r = '0;
        end else if (s_bus.ack || s_bus.err) begin
            s_bus.ack = 0; s_bus.err = 0; sbusy = 0;
        end else if (s_bus.cyc && s_bus.stb) begin
            if (!sbusy) begin
                sbusy = 1; scyc_cnt++;
                slat = $urandom_range(lat_hi, lat_lo);
                if (sq.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL unexpected_slave_cycle adr=0x%08h", s_bus.adr);
                    cur = '{adr: '0, we: 0, dat: '0, sel: '0, err: 0};
                end else begin
                    cur = sq.pop_front();
                    chk("s_adr", 32'(s_bus.adr), 32'(cur.adr));
                    chk("s_we", 32'(s_bus.we), 32'(cur.we));
                    if (cur.we) begin
                        chk("s_dat", s_bus.dat_w, cur.dat);
                        chk("s_sel", 32'(s_bus.sel), 32'(cur.sel));
                    end
                end
            end
            if (slat == 0) begin
                if (cur.err) s_bus.err = 1;
                else begin
                    s_bus.ack = 1;
                    if (s_bus.we) smem[s_bus.adr] = merge(sget(s_bus.adr), s_bus.dat_w, s_bus.sel);
                    s_bus.dat_r = sget(s_bus.adr);
                end
            end else slat--;
        end
    end

    // Master-side monitor.
    resp_t e_m;
    always @(negedge sys_clk) if (sys_rst_n) begin
        if (miss_o) miss_cnt++;
        if (m_bus.ack || m_bus.err) begin
            term_cnt++;
            if (rq.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL unexpected_termination ack=%0b err=%0b", m_bus.ack, m_bus.err);
            end else begin
                e_m = rq.pop_front();
                chk("m_err", 32'(m_bus.err), 32'(e_m.err));
                chk("m_ack", 32'(m_bus.ack), 32'(!e_m.err));
                chk("miss_o", 32'(miss_o), 32'(e_m.fault));
                if (e_m.fault) chk("fault_vaddr", fault_vaddr, e_m.va);
                if (e_m.rd && !e_m.err) chk("m_dat", m_bus.dat_r, e_m.dat);
            end
        end
    end

    task automatic access(input logic [31:0] va, input bit we, input logic [31:0] dat,
                          input logic [3:0] sel, output int k);
        logic [29:0] pa;
        bit ok, serr;
        resp_t e;
        ok   = model_xlate(va, tlb_en, pa);
        serr = ok && allow_serr && ($urandom_range(0, 15) == 0);
        e = '{err: !ok || serr, fault: !ok, rd: !we, dat: '0, va: va};
        if (!ok) n_fault++;
        if (ok) begin
            sq.push_back('{adr: pa, we: we, dat: dat, sel: sel, err: serr});
            if (!serr) begin
                if (we) rmem[pa] = merge(rget(pa), dat, sel);
                else    e.dat = rget(pa);
            end
        end
        rq.push_back(e);
        @(posedge sys_clk); #1;
        m_bus.adr = va; m_bus.we = we; m_bus.dat_w = dat; m_bus.sel = sel;
        m_bus.cyc = 1; m_bus.stb = 1;
        k = 0;
        while (k < 50) begin
            @(negedge sys_clk);
            if (m_bus.ack || m_bus.err) break;
            k++;
        end
        if (k == 50) begin n_vec++; n_miss++; $display("FAIL access_timeout va=0x%08h", va); end
        @(posedge sys_clk); #1;
        m_bus.cyc = 0; m_bus.stb = 0;
    endtask

    task automatic tlb_write(input logic [VW-1:0] vpn, input logic [VW-1:0] ppn, input bit v, input bit fl);
        @(posedge sys_clk); #1;
        tlb_wr = 1; tlb_wr_vpn = vpn; tlb_wr_ppn = ppn; tlb_wr_v = v; tlb_flush = fl;
        @(posedge sys_clk); #1;
        tlb_wr = 0; tlb_flush = 0;
        if (fl) model_flush();
        model_write(vpn, ppn, v);
    endtask

    task automatic pulse_flush();
        @(posedge sys_clk); #1; tlb_flush = 1;
        @(posedge sys_clk); #1; tlb_flush = 0;
        model_flush();
    endtask

    task automatic wait_scyc();
        int t = 0;
        while (!s_bus.cyc && t < 20) begin @(negedge sys_clk); t++; end
        if (!s_bus.cyc) begin n_vec++; n_miss++; $display("FAIL wait_s_cyc timeout"); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int k, t0, s0;
    logic [VW-1:0] pool[12];
    logic [29:0] pa;
    initial begin
        m_bus.adr = '0; m_bus.dat_w = '0; m_bus.sel = '0; m_bus.cyc = 0; m_bus.stb = 0;
        m_bus.we = 0; m_bus.cti = '0; m_bus.bte = '0;
        tlb_en = 0; tlb_wr = 0; tlb_wr_v = 0; tlb_flush = 0; tlb_wr_vpn = '0; tlb_wr_ppn = '0;
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1;
        @(negedge sys_clk);
        chk("rst_s_cyc", 32'(s_bus.cyc), 0);
        chk("rst_m_ack", 32'(m_bus.ack), 0);
        chk("rst_m_err", 32'(m_bus.err), 0);
        chk("rst_miss", 32'(miss_o), 0);
        chk("rst_fault_vaddr", fault_vaddr, 0);

        // Identity map, fixed slave latency to check the 2-cycle overhead.
        lat_lo = 0; lat_hi = 0;
        access(32'h0000_1004, 0, '0, 4'hF, k); chk("lat_identity_0", k, 2);
        lat_lo = 2; lat_hi = 2;
        access(32'h0000_1004, 0, '0, 4'hF, k); chk("lat_identity_2", k, 4);

        // Translated store then readback.
        lat_lo = 0; lat_hi = 3;
        tlb_en = 1;
        tlb_write(20'h40000, 20'h00002, 1, 0);
        access(32'h4000_0010, 1, 32'hDEAD_BEEF, 4'hF, k);
        access(32'h4000_0010, 0, '0, 4'hF, k);

        // Unmapped load faults without any slave cycle.
        s0 = scyc_cnt;
        access(32'h1234_5678, 0, '0, 4'hF, k); chk("fault_lat", k, 2);
        chk("fault_no_slave", scyc_cnt, s0);

        // Overfill: first VPN evicted; rewrite keeps the pointer.
        pulse_flush();
        for (int i = 0; i <= ENTRIES; i++) tlb_write(VW'(20'h100 + i), VW'(20'h300 + i), 1, 0);
        for (int i = 0; i <= ENTRIES; i++) access({VW'(20'h100 + i), 12'h0A4}, 0, '0, 4'hF, k);
        tlb_write(20'h102, 20'h3FF, 1, 0);
        tlb_write(20'h1FF, 20'h3EE, 1, 0);
        access(32'h0010_1000, 0, '0, 4'hF, k);
        access(32'h0010_2008, 0, '0, 4'hF, k);
        access(32'h001F_F00C, 1, 32'h0BAD_F00D, 4'h3, k);
        access(32'h0010_3000, 0, '0, 4'hF, k);

        // Flush while an access is in flight.
        tlb_write(20'h00555, 20'h000AA, 1, 0);
        lat_lo = 2; lat_hi = 2;
        fork
            access(32'h0055_5120, 0, '0, 4'hF, k);
            begin wait_scyc(); pulse_flush(); end
        join
        lat_lo = 0; lat_hi = 3;
        access(32'h0055_5120, 0, '0, 4'hF, k);

        // Flush and write in the same cycle.
        tlb_write(20'h00666, 20'h00123, 1, 0);
        tlb_write(20'h00777, 20'h00456, 1, 1);
        access(32'h0077_7004, 0, '0, 4'hF, k);
        access(32'h0066_6004, 0, '0, 4'hF, k);

        // Abort during LOOKUP.
        t0 = term_cnt; s0 = scyc_cnt;
        @(posedge sys_clk); #1;
        m_bus.adr = 32'h0077_7000; m_bus.we = 0; m_bus.cyc = 1; m_bus.stb = 1;
        @(posedge sys_clk); #1;
        m_bus.cyc = 0; m_bus.stb = 0;
        repeat (6) @(posedge sys_clk);
        chk("abort_no_term", term_cnt, t0);
        chk("abort_no_slave", scyc_cnt, s0);

        // Reset during ISSUE.
        lat_lo = 3; lat_hi = 3;
        void'(model_xlate(32'h0077_7000, 1, pa));
        sq.push_back('{adr: pa, we: 0, dat: '0, sel: 4'hF, err: 0});
        @(posedge sys_clk); #1;
        m_bus.adr = 32'h0077_7000; m_bus.cyc = 1; m_bus.stb = 1;
        wait_scyc();
        #1 sys_rst_n = 0;
        #1;
        chk("rstmid_s_cyc", 32'(s_bus.cyc), 0);
        chk("rstmid_m_ack", 32'(m_bus.ack), 0);
        chk("rstmid_m_err", 32'(m_bus.err), 0);
        chk("rstmid_fault_vaddr", fault_vaddr, 0);
        m_bus.cyc = 0; m_bus.stb = 0;
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1;
        lat_lo = 0; lat_hi = 3;
        access(32'h0077_7000, 0, '0, 4'hF, k);

        // Random traffic.
        for (int i = 0; i < 12; i++) pool[i] = (i == 0) ? '0 : VW'($urandom);
        allow_serr = 1;
        for (int i = 0; i < 300; i++) begin
            int op = $urandom_range(0, 15);
            if (op == 0) pulse_flush();
            else if (op <= 3)
                tlb_write(pool[$urandom_range(0, 11)], VW'($urandom), $urandom_range(0, 7) != 0, 0);
            else begin
                tlb_en = ($urandom_range(0, 3) != 0);
                access({pool[$urandom_range(0, 11)], 12'($urandom)}, $urandom_range(0, 1) == 1,
                       $urandom, 4'($urandom_range(1, 15)), k);
            end
        end
        allow_serr = 0;
        repeat (4) @(posedge sys_clk);
        chk("miss_pulse_count", miss_cnt, n_fault);
        chk("resp_queue_empty", rq.size(), 0);
        chk("slave_queue_empty", sq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
